// File: rtl/bus_region_router.sv
// Single-master to N-slave router: decodes the address region, forwards a registered
// request to the selected slave, and returns its data or an error with sticky fault capture.
module bus_region_router #(
    parameter int NUM_SLAVES  = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int REGION_BITS = 4,
    parameter logic [NUM_SLAVES*REGION_BITS-1:0] SLAVE_REGIONS = {4'h3, 4'h2, 4'h1, 4'h0},
    parameter bit STRIP_REGION = 1'b1,
    parameter int TIMEOUT      = 255
) (
    input  logic                         i_clock,
    input  logic                         i_reset_n,
    input  logic                         i_request,
    input  logic                         i_rw,
    input  logic [ADDR_W-1:0]            i_address,
    input  logic [DATA_W-1:0]            i_wdata,
    output logic [DATA_W-1:0]            o_rdata,
    output logic                         o_ready,
    output logic                         o_error,
    output logic [NUM_SLAVES-1:0]        o_slave_request,
    output logic                         o_slave_rw,
    output logic [ADDR_W-1:0]            o_slave_address,
    output logic [DATA_W-1:0]            o_slave_wdata,
    input  logic [NUM_SLAVES*DATA_W-1:0] i_slave_rdata,
    input  logic [NUM_SLAVES-1:0]        i_slave_ready,
    input  logic                         i_fault_clear,
    output logic                         o_fault,
    output logic [1:0]                   o_fault_cause,
    output logic [ADDR_W-1:0]            o_fault_address,
    output logic                         o_fault_rw
);

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [ADDR_W-1:0] REGION_MASK =
        {{REGION_BITS{1'b1}}, {(ADDR_W-REGION_BITS){1'b0}}};
    localparam logic [1:0] CAUSE_UNMAPPED = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

    state_t             state;
    logic [SEL_W-1:0]   sel_q;
    logic [CNT_W-1:0]   count;
    logic               err_q;
    logic [ADDR_W-1:0]  addr_q;

    logic               dec_hit;
    logic [SEL_W-1:0]   dec_sel;
    logic               sel_ready;
    logic [DATA_W-1:0]  sel_rdata;
    logic               timeout_hit;
    logic               miss_event;
    logic               timeout_event;

    // Descending scan so the lowest matching slave index is the one left standing.
    always_comb begin
        dec_hit = 1'b0;
        dec_sel = '0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if (i_address[ADDR_W-1 -: REGION_BITS] == SLAVE_REGIONS[k*REGION_BITS +: REGION_BITS]) begin
                dec_hit = 1'b1;
                dec_sel = SEL_W'(k);
            end
        end
    end

    assign sel_ready     = i_slave_ready[sel_q];
    assign sel_rdata     = i_slave_rdata[int'(sel_q)*DATA_W +: DATA_W];
    assign timeout_hit   = (TIMEOUT != 0) && (count == CNT_W'(TIMEOUT - 1));
    assign miss_event    = (state == IDLE) && i_request && !dec_hit;
    assign timeout_event = (state == ACCESS) && !sel_ready && timeout_hit;

    // NOTE: every register below uses <= so all updates see the same pre-edge values.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state           <= IDLE;
            sel_q           <= '0;
            count           <= '0;
            err_q           <= 1'b0;
            addr_q          <= '0;
            o_rdata         <= '0;
            o_ready         <= 1'b0;
            o_error         <= 1'b0;
            o_slave_request <= '0;
            o_slave_rw      <= 1'b0;
            o_slave_address <= '0;
            o_slave_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    o_ready <= 1'b0;
                    o_error <= 1'b0;
                    if (i_request) begin
                        addr_q          <= i_address;
                        o_slave_rw      <= i_rw;
                        o_slave_address <= STRIP_REGION ? (i_address & ~REGION_MASK) : i_address;
                        o_slave_wdata   <= i_wdata;
                        o_rdata         <= '0;
                        count           <= '0;
                        sel_q           <= dec_sel;
                        if (dec_hit) begin
                            o_slave_request <= NUM_SLAVES'(1) << dec_sel;
                            err_q           <= 1'b0;
                            state           <= ACCESS;
                        end else begin
                            err_q <= 1'b1;
                            state <= RESPOND;
                        end
                    end
                end
                ACCESS: begin
                    // Ready is tested first so a ready landing on the timeout cycle completes cleanly.
                    if (sel_ready) begin
                        o_rdata         <= o_slave_rw ? '0 : sel_rdata;
                        o_slave_request <= '0;
                        state           <= RESPOND;
                    end else if (timeout_hit) begin
                        o_slave_request <= '0;
                        err_q           <= 1'b1;
                        state           <= RESPOND;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                RESPOND: begin
                    if (i_request) begin
                        o_ready <= 1'b1;
                        o_error <= err_q;
                    end else begin
                        o_ready <= 1'b0;
                        o_error <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky first-fault capture; a clear coinciding with a new fault still records it.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_fault         <= 1'b0;
            o_fault_cause   <= 2'b00;
            o_fault_address <= '0;
            o_fault_rw      <= 1'b0;
        end else begin
            if (i_fault_clear) begin
                o_fault         <= 1'b0;
                o_fault_cause   <= 2'b00;
                o_fault_address <= '0;
                o_fault_rw      <= 1'b0;
            end
            if ((miss_event || timeout_event) && (!o_fault || i_fault_clear)) begin
                o_fault         <= 1'b1;
                o_fault_cause   <= miss_event ? CAUSE_UNMAPPED : CAUSE_TIMEOUT;
                o_fault_address <= miss_event ? i_address : addr_q;
                o_fault_rw      <= miss_event ? i_rw : o_slave_rw;
            end
        end
    end

endmodule

// File: tb/tb_bus_region_router.sv
// Directed bench for bus_region_router: latency, address strip, unmapped, timeout,
// ready/timeout race, fault clear race and mid-transaction reset.
module tb_bus_region_router;

    logic         clk;
    logic         rst_n;
    logic         request;
    logic         rw;
    logic [31:0]  address;
    logic [31:0]  wdata;
    logic [31:0]  rdata;
    logic         ready;
    logic         error;
    logic [3:0]   slave_request;
    logic         slave_rw;
    logic [31:0]  slave_address;
    logic [31:0]  slave_wdata;
    logic [127:0] slave_rdata;
    logic [3:0]   slave_ready;
    logic         fault_clear;
    logic         fault;
    logic [1:0]   fault_cause;
    logic [31:0]  fault_address;
    logic         fault_rw;

    int errors = 0;
    int checks = 0;

    bus_region_router #(.TIMEOUT(8)) dut (
        .i_clock(clk), .i_reset_n(rst_n),
        .i_request(request), .i_rw(rw), .i_address(address), .i_wdata(wdata),
        .o_rdata(rdata), .o_ready(ready), .o_error(error),
        .o_slave_request(slave_request), .o_slave_rw(slave_rw),
        .o_slave_address(slave_address), .o_slave_wdata(slave_wdata),
        .i_slave_rdata(slave_rdata), .i_slave_ready(slave_ready),
        .i_fault_clear(fault_clear), .o_fault(fault), .o_fault_cause(fault_cause),
        .o_fault_address(fault_address), .o_fault_rw(fault_rw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic r, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        request = 1'b1;
        rw      = r;
        address = a;
        wdata   = d;
    endtask

    task automatic drop_req();
        @(negedge clk);
        request     = 1'b0;
        slave_ready = '0;
    endtask

    task automatic pulse_fault_clear();
        @(negedge clk);
        fault_clear = 1'b1;
        @(negedge clk);
        fault_clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; request = 0; rw = 0; address = '0; wdata = '0;
        slave_rdata = '0; slave_ready = '0; fault_clear = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ready, error, slave_request, fault, rdata, slave_address} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b error=%b sreq=%b fault=%b rdata=%h saddr=%h, expected all 0",
                     ready, error, slave_request, fault, rdata, slave_address);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_read_latency();
        slave_rdata[32 +: 32] = 32'hCAFEBABE;
        slave_ready = 4'b0010;
        start_req(1'b0, 32'h1000_0004, 32'h0);
        tick();
        checks++;
        if (slave_request !== 4'b0010 || ready !== 1'b0) begin
            errors++;
            $display("FAIL read_cycle1: got sreq=%b ready=%b, expected sreq=0010 ready=0", slave_request, ready);
        end
        tick();
        checks++;
        if (slave_request !== 4'b0000 || ready !== 1'b0) begin
            errors++;
            $display("FAIL read_cycle2: got sreq=%b ready=%b, expected sreq=0000 ready=0", slave_request, ready);
        end
        tick();
        checks++;
        if (ready !== 1'b1 || error !== 1'b0 || rdata !== 32'hCAFEBABE) begin
            errors++;
            $display("FAIL read_cycle3: got ready=%b error=%b rdata=%h, expected 1 0 cafebabe", ready, error, rdata);
        end
        drop_req();
        tick();
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL read_release: got ready=%b, expected 0", ready);
        end
    endtask

    task automatic test_write_strip();
        slave_ready = 4'b0100;  // ready from a slave that is not selected
        start_req(1'b1, 32'h1000_0040, 32'h1234_5678);
        tick();
        checks++;
        if (slave_address !== 32'h0000_0040 || slave_rw !== 1'b1 || slave_wdata !== 32'h1234_5678 || slave_request !== 4'b0010) begin
            errors++;
            $display("FAIL write_latch: got saddr=%h srw=%b swdata=%h sreq=%b, expected 00000040 1 12345678 0010",
                     slave_address, slave_rw, slave_wdata, slave_request);
        end
        repeat (3) tick();
        checks++;
        if (slave_request !== 4'b0010 || slave_wdata !== 32'h1234_5678 || ready !== 1'b0) begin
            errors++;
            $display("FAIL write_hold: got sreq=%b swdata=%h ready=%b, expected 0010 12345678 0", slave_request, slave_wdata, ready);
        end
        @(negedge clk);
        slave_ready = 4'b0010;
        slave_rdata[32 +: 32] = 32'hDEAD_BEEF;
        tick();
        checks++;
        if (slave_request !== 4'b0000) begin
            errors++;
            $display("FAIL write_drop: got sreq=%b, expected 0000", slave_request);
        end
        tick();
        checks++;
        if (ready !== 1'b1 || error !== 1'b0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL write_resp: got ready=%b error=%b rdata=%h, expected 1 0 00000000", ready, error, rdata);
        end
        drop_req();
        tick();
    endtask

    task automatic test_unmapped();
        start_req(1'b0, 32'h9000_0000, 32'h0);
        tick();
        checks++;
        if (fault !== 1'b1 || fault_cause !== 2'b01 || fault_address !== 32'h9000_0000 || fault_rw !== 1'b0 || slave_request !== 4'b0) begin
            errors++;
            $display("FAIL unmapped_capture: got fault=%b cause=%b faddr=%h frw=%b sreq=%b, expected 1 01 90000000 0 0000",
                     fault, fault_cause, fault_address, fault_rw, slave_request);
        end
        tick();
        checks++;
        if (ready !== 1'b1 || error !== 1'b1 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL unmapped_resp: got ready=%b error=%b rdata=%h, expected 1 1 00000000", ready, error, rdata);
        end
        drop_req();
        tick();
    endtask

    task automatic test_timeout();
        pulse_fault_clear();
        checks++;
        if (fault !== 1'b0 || fault_cause !== 2'b00 || fault_address !== 32'h0) begin
            errors++;
            $display("FAIL fault_clear: got fault=%b cause=%b faddr=%h, expected 0 00 00000000", fault, fault_cause, fault_address);
        end
        start_req(1'b0, 32'h2000_0010, 32'h0);
        tick();
        repeat (7) tick();
        checks++;
        if (slave_request !== 4'b0100 || fault !== 1'b0) begin
            errors++;
            $display("FAIL timeout_wait: got sreq=%b fault=%b, expected 0100 0", slave_request, fault);
        end
        tick();
        checks++;
        if (slave_request !== 4'b0 || fault !== 1'b1 || fault_cause !== 2'b10 || fault_address !== 32'h2000_0010 || fault_rw !== 1'b0) begin
            errors++;
            $display("FAIL timeout_capture: got sreq=%b fault=%b cause=%b faddr=%h frw=%b, expected 0000 1 10 20000010 0",
                     slave_request, fault, fault_cause, fault_address, fault_rw);
        end
        tick();
        checks++;
        if (ready !== 1'b1 || error !== 1'b1 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL timeout_resp: got ready=%b error=%b rdata=%h, expected 1 1 00000000", ready, error, rdata);
        end
        drop_req();
        tick();
        start_req(1'b1, 32'hA000_0000, 32'h0);
        tick();
        checks++;
        if (fault_cause !== 2'b10 || fault_address !== 32'h2000_0010 || fault_rw !== 1'b0) begin
            errors++;
            $display("FAIL fault_sticky: got cause=%b faddr=%h frw=%b, expected 10 20000010 0", fault_cause, fault_address, fault_rw);
        end
        tick();
        drop_req();
        tick();
    endtask

    task automatic test_race();
        pulse_fault_clear();
        slave_rdata[96 +: 32] = 32'h55AA_55AA;
        start_req(1'b0, 32'h3000_0000, 32'h0);
        tick();
        repeat (7) tick();
        @(negedge clk);
        slave_ready = 4'b1000;
        tick();
        checks++;
        if (slave_request !== 4'b0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL race_ready_wins: got sreq=%b fault=%b, expected 0000 0", slave_request, fault);
        end
        tick();
        checks++;
        if (ready !== 1'b1 || error !== 1'b0 || rdata !== 32'h55AA_55AA) begin
            errors++;
            $display("FAIL race_resp: got ready=%b error=%b rdata=%h, expected 1 0 55aa55aa", ready, error, rdata);
        end
        drop_req();
        tick();
        start_req(1'b0, 32'hB000_0000, 32'h0);
        tick();
        drop_req();
        tick();
        start_req(1'b1, 32'hC000_0004, 32'h0);
        fault_clear = 1'b1;
        tick();
        checks++;
        if (fault !== 1'b1 || fault_cause !== 2'b01 || fault_address !== 32'hC000_0004 || fault_rw !== 1'b1) begin
            errors++;
            $display("FAIL clear_with_fault: got fault=%b cause=%b faddr=%h frw=%b, expected 1 01 c0000004 1",
                     fault, fault_cause, fault_address, fault_rw);
        end
        @(negedge clk);
        fault_clear = 1'b0;
        drop_req();
        tick();
    endtask

    task automatic test_reset_mid();
        start_req(1'b0, 32'h0000_0100, 32'h0);
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (slave_request !== 4'b0 || ready !== 1'b0 || fault !== 1'b0 || slave_address !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: got sreq=%b ready=%b fault=%b saddr=%h, expected all 0", slave_request, ready, fault, slave_address);
        end
        request = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        slave_rdata[0 +: 32] = 32'h0BAD_F00D;
        slave_ready = 4'b0001;
        start_req(1'b0, 32'h0000_0100, 32'h0);
        repeat (3) tick();
        checks++;
        if (ready !== 1'b1 || error !== 1'b0 || rdata !== 32'h0BAD_F00D || slave_address !== 32'h0000_0100) begin
            errors++;
            $display("FAIL after_reset: got ready=%b error=%b rdata=%h saddr=%h, expected 1 0 0badf00d 00000100",
                     ready, error, rdata, slave_address);
        end
        drop_req();
        tick();
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_release: got ready=%b, expected 0", ready);
        end
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_write_strip();
        test_unmapped();
        test_timeout();
        test_race();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
